// File: rtl/blink_ctrl.sv
// blink_ctrl: status LED mode controller and blink scheduler.
// Produces a single-cycle TICK enable from a prescaler, debounces MODEBTN,
// steps a 4-state mode FSM on each accepted press and drives LED1 with the
// blink pattern for the current mode.
// Optional build macro: BLINK_CTRL_AUTO_EN adds an inactivity counter that
// advances the mode after AUTO_TICKS ticks without a press.
module blink_ctrl #(
    parameter int SYS_CLK         = 100000000,
    parameter int TICK_HZ         = 8,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int AUTO_TICKS      = 80
) (
    input  logic       CLK,
    input  logic       RESETBTN,
    input  logic       MODEBTN,
    output logic       LED1,
    output logic [1:0] MODE,
    output logic       TICK
);

    localparam int DIV = SYS_CLK / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_SLOW  = 2'b01,
        M_FAST  = 2'b10,
        M_PULSE = 2'b11
    } mode_t;

    // Reject parameter sets that make the prescaler or debounce meaningless.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("blink_ctrl: SYS_CLK/TICK_HZ must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("blink_ctrl: DEBOUNCE_CYCLES must be >= 1");
        end
        if (AUTO_TICKS < 1) begin : g_bad_auto
            $error("blink_ctrl: AUTO_TICKS must be >= 1");
        end
    endgenerate

    logic          sync1;
    logic          btn_s;
    logic          btn_d;
    logic [DW-1:0] dcnt;
    logic          press;

    mode_t         mode;
    logic [PW-1:0] pcnt;
    logic [2:0]    phase;
    logic          wrap;
    logic          advance;
    logic          led_next;

    // Two-flop synchronizer, debounce counter and registered press pulse.
    always_ff @(posedge CLK or posedge RESETBTN) begin
        if (RESETBTN) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            btn_d <= 1'b0;
            dcnt  <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= MODEBTN;
            btn_s <= sync1;
            press <= 1'b0;
            if (btn_s == btn_d) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                btn_d <= btn_s;
                dcnt  <= '0;
                press <= btn_s;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign wrap = (pcnt == P_LAST);

`ifdef BLINK_CTRL_AUTO_EN
    localparam int IW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(AUTO_TICKS - 1);

    logic [IW-1:0] icnt;
    logic          auto_fire;

    assign auto_fire = wrap && (icnt == I_LAST);
    assign advance   = press | auto_fire;

    // Inactivity counter: counts ticks since the last mode advance.
    always_ff @(posedge CLK or posedge RESETBTN) begin
        if (RESETBTN) begin
            icnt <= '0;
        end else if (press || auto_fire) begin
            icnt <= '0;
        end else if (wrap) begin
            icnt <= icnt + 1'b1;
        end
    end
`else
    assign advance = press;
`endif

    // Blink pattern for the current mode and phase.
    always_comb begin
        led_next = 1'b0;
        case (mode)
            M_OFF:   led_next = 1'b0;
            M_SLOW:  led_next = phase[2];
            M_FAST:  led_next = phase[0];
            M_PULSE: led_next = (phase == 3'd0);
            default: led_next = 1'b0;
        endcase
    end

    // Mode FSM with prescaler, phase and registered TICK/LED1; an advance
    // overrides a coincident wrap so each mode starts at phase 0.
    always_ff @(posedge CLK or posedge RESETBTN) begin
        if (RESETBTN) begin
            mode  <= M_SLOW;
            pcnt  <= '0;
            phase <= 3'd0;
            TICK  <= 1'b0;
            LED1  <= 1'b0;
        end else begin
            LED1 <= led_next;
            if (advance) begin
                case (mode)
                    M_OFF:   mode <= M_SLOW;
                    M_SLOW:  mode <= M_FAST;
                    M_FAST:  mode <= M_PULSE;
                    M_PULSE: mode <= M_OFF;
                    default: mode <= M_SLOW;
                endcase
                pcnt  <= '0;
                phase <= 3'd0;
                TICK  <= 1'b0;
            end else begin
                TICK <= wrap;
                if (wrap) begin
                    pcnt  <= '0;
                    phase <= phase + 3'd1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end

    assign MODE = mode;

endmodule

// File: tb/tb_blink_ctrl.sv
// tb_blink_ctrl: directed and randomized checks of blink_ctrl against a
// behavioural model built on "edges since the mode started" arithmetic.
module tb_blink_ctrl;

    localparam int DIV  = 10;
    localparam int DB   = 5;
    localparam int AUTO = 4;

    logic       CLK = 1'b0;
    logic       RESETBTN;
    logic       MODEBTN;
    logic       LED1;
    logic [1:0] MODE;
    logic       TICK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   m_mode;
    int   m_k;      // edges since reset or last mode advance
    int   m_run;    // consecutive edges with synchronized level != accepted level
    logic m_led, m_tick, m_s1, m_s2, m_d, m_press;

    blink_ctrl #(
        .SYS_CLK(100),
        .TICK_HZ(10),
        .DEBOUNCE_CYCLES(5),
        .AUTO_TICKS(4)
    ) dut (
        .CLK(CLK),
        .RESETBTN(RESETBTN),
        .MODEBTN(MODEBTN),
        .LED1(LED1),
        .MODE(MODE),
        .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic pattern(input int mode, input int ph);
        case (mode)
            0:       return 1'b0;
            1:       return (ph >= 4);
            2:       return (ph % 2 == 1);
            default: return (ph == 0);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 1; m_k = 0; m_run = 0;
        m_led = 0; m_tick = 0; m_s1 = 0; m_s2 = 0; m_d = 0; m_press = 0;
    endtask

    task automatic model_edge(input logic raw);
        int   old_mode, old_ph, kn;
        logic adv;
        old_mode = m_mode;
        old_ph   = (m_k / DIV) % 8;
        adv      = m_press;
        kn       = m_k + 1;
`ifdef BLINK_CTRL_AUTO_EN
        if (!adv && (kn % DIV == 0) && (kn / DIV == AUTO)) adv = 1'b1;
`endif
        if (adv) begin
            m_mode = (m_mode + 1) % 4;
            m_k    = 0;
            m_tick = 1'b0;
        end else begin
            m_k    = kn;
            m_tick = (kn % DIV == 0);
        end
        m_led   = pattern(old_mode, old_ph);
        m_press = 1'b0;
        if (m_s2 != m_d) begin
            m_run++;
            if (m_run == DB) begin
                m_d     = m_s2;
                m_run   = 0;
                m_press = m_s2;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("mode", {30'd0, MODE}, m_mode);
        chk("led", {31'd0, LED1}, {31'd0, m_led});
        chk("tick", {31'd0, TICK}, {31'd0, m_tick});
    endtask

    task automatic step(input logic b);
        MODEBTN = b;
        @(posedge CLK);
        model_edge(b);
        #1;
        check_outputs();
    endtask

    // Assert reset between edges, check outputs at once, release after two edges.
    task automatic do_reset();
        #3;
        RESETBTN = 1'b1;
        MODEBTN  = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_mode", {30'd0, MODE}, 32'd1);
        chk("rst_led", {31'd0, LED1}, 32'd0);
        chk("rst_tick", {31'd0, TICK}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESETBTN = 1'b0;
    endtask

    initial begin
        int   cnt;
        int   len;
        logic lvl;
        int   exp_seq [4];
        exp_seq = '{2, 3, 0, 1};

        RESETBTN = 1'b1;
        MODEBTN  = 1'b0;
        do_reset();

        // Free-running pattern after reset release
        for (int i = 0; i < 100; i++) step(1'b0);

        // Clean press held 50 cycles
        for (int i = 0; i < 80; i++) begin
            step(i < 50);
`ifndef BLINK_CTRL_AUTO_EN
            if (i == 6)  chk("press_before", {30'd0, MODE}, 32'd1);
            if (i == 7)  chk("press_edge7", {30'd0, MODE}, 32'd2);
            if (i == 79) chk("press_held", {30'd0, MODE}, 32'd2);
`endif
        end

        // Bounce shorter than the debounce window
        do_reset();
        for (int i = 0; i < 28; i++) step((i < 3) || (i >= 5 && i < 8));
`ifndef BLINK_CTRL_AUTO_EN
        chk("bounce_none", {30'd0, MODE}, 32'd1);
`endif
        for (int i = 0; i < 30; i++) step(i < 10);
`ifndef BLINK_CTRL_AUTO_EN
        chk("bounce_then_press", {30'd0, MODE}, 32'd2);
`endif

        // Four presses through all modes, PULSE duty measured after the second
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 30; i++) step(i < 10);
`ifndef BLINK_CTRL_AUTO_EN
            chk("seq_mode", {30'd0, MODE}, exp_seq[p]);
`endif
            if (p == 1) begin
                cnt = 0;
                for (int i = 0; i < 80; i++) begin
                    step(1'b0);
                    if (LED1 === 1'b1) cnt++;
                end
`ifndef BLINK_CTRL_AUTO_EN
                chk("pulse_duty", cnt, 32'd10);
`endif
            end
        end

        // Press pulse coincident with a prescaler wrap
        do_reset();
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 30; i++) begin
            step(i < 12);
`ifndef BLINK_CTRL_AUTO_EN
            if (i == 7) begin
                chk("align_mode", {30'd0, MODE}, 32'd2);
                chk("align_notick", {31'd0, TICK}, 32'd0);
            end
            if (i == 16) chk("align_tick_early", {31'd0, TICK}, 32'd0);
            if (i == 17) chk("align_tick_next", {31'd0, TICK}, 32'd1);
`endif
        end

        // Reset in the middle of a debounce
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1);
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b0);
`ifndef BLINK_CTRL_AUTO_EN
        chk("midreset_mode", {30'd0, MODE}, 32'd1);
`endif

        // Randomized button activity with occasional resets
        lvl = 1'b0;
        for (int n = 0; n < 80; n++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(lvl);
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        for (int i = 0; i < 40; i++) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_ctrl.md
# blink_ctrl

Mode controller and scheduler for the on-board status LED. It turns the system clock into a single-cycle tick enable with a prescaler, so no derived clock is used. It debounces a mode push-button and steps a 4-state mode FSM, then drives LED1 with the blink pattern for the current mode. It sits between the board pins (CLK, buttons, LED1) and any logic that needs to observe the current mode or the tick.

## Interface
- SYS_CLK, 100000000, system clock frequency in Hz
- TICK_HZ, 8, tick rate in Hz; DIV = SYS_CLK/TICK_HZ; DIV must be >= 2
- DEBOUNCE_CYCLES, 2000000, clock cycles the synchronized button must hold a new level before it is accepted (20 ms at 100 MHz); must be >= 1
- AUTO_TICKS, 80, ticks of button inactivity before an auto-advance (only with BLINK_CTRL_AUTO_EN)
- CLK  input  1  system clock; all state is on the rising edge
- RESETBTN  input  1  reset, asynchronous assert, active-high; it is not synchronized internally
- MODEBTN  input  1  raw mode button, asynchronous to CLK, active-high
- LED1  output  1  registered LED drive
- MODE  output  2  current mode: 00 OFF, 01 SLOW, 10 FAST, 11 PULSE
- TICK  output  1  one-cycle pulse at TICK_HZ

## Operation
- Reset values:
  - MODE=01 (SLOW); LED1=0; TICK=0
  - Prescaler, phase, debounce counter, synchronizer and debounced level are all 0
- Synchronizer: MODEBTN passes through a 2-FF synchronizer to give btn_s.
- Debounce:
  - The counter clears whenever btn_s equals the debounced level btn_d.
  - Otherwise it increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_d takes btn_s and the counter clears.
- Press: a btn_d 0->1 transition produces a one-cycle press pulse. Releases and holds produce nothing.
- Mode FSM: on a press pulse, MODE advances OFF->SLOW->FAST->PULSE->OFF on the next edge.
  - On that same edge the prescaler and the 3-bit phase clear to 0, so every mode starts at phase 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - TICK is registered high for exactly one cycle when the count equals DIV-1.
  - Counter width is ceil(log2(DIV)).
- Phase: a 3-bit counter that increments on TICK and wraps 7->0.
- LED1 pattern, registered from MODE and phase:
  - OFF: LED1 = 0
  - SLOW: LED1 = phase[2], which is 1 Hz at TICK_HZ=8
  - FAST: LED1 = phase[0], which is 4 Hz
  - PULSE: LED1 = (phase==0), one tick on in every 8

## Timing
- MODEBTN rises and stays high before edge 0.
  - btn_s is high after edge 1.
  - btn_d is high after edge 1+DEBOUNCE_CYCLES.
  - The press pulse is high in the following cycle.
  - MODE changes at edge 2+DEBOUNCE_CYCLES.
- A bounce shorter than DEBOUNCE_CYCLES produces no press. Any mismatch gap restarts the count.
- A held button gives exactly one advance. A release must itself be debounced before the next press is counted.
- LED1 follows phase with 1 cycle of latency, i.e. it updates the cycle after TICK.
- Press and prescaler wrap on the same edge: the mode change wins. The prescaler and phase clear, and no phase increment occurs.
- Reset asserted mid-debounce or mid-pattern: all state returns to reset values immediately (asynchronously). The first TICK after release comes DIV cycles later.

## Configuration
- BLINK_CTRL_AUTO_EN defined:
  - An inactivity counter increments on each TICK and clears on any press.
  - When it reaches AUTO_TICKS-1 on a TICK, the mode advances exactly as a press would, including clearing the prescaler and phase, and the counter clears.
- BLINK_CTRL_AUTO_EN undefined: the inactivity counter is absent and the mode changes only by button.

## Test plan
Bench parameters for all scenarios: SYS_CLK=100, TICK_HZ=10 (DIV=10), DEBOUNCE_CYCLES=5, AUTO_TICKS=4.
- Reset release:
  - MODE=01, LED1=0.
  - TICK pulses at cycles 10, 20, 30…
  - LED1 goes 1 one cycle after the 4th TICK and 0 one cycle after the 8th TICK.
- Clean press at edge 0, held 50 cycles:
  - MODE goes 01->10 at edge 7.
  - No further change while held.
  - After FAST mode is entered, LED1 toggles one cycle after every TICK.
- Bounce:
  - MODEBTN high 3 cycles, low 2, high 3, then low: MODE stays 01.
  - A subsequent 10-cycle press advances MODE to 10.
- Four debounced presses: MODE sequence 01->10->11->00->01. In PULSE, LED1 is high for exactly 10 cycles of every 80.
- Press aligned so the press pulse coincides with a prescaler wrap:
  - MODE advances, phase=0, and there is no TICK in that cycle.
  - The next TICK comes 10 cycles later.
- Reset asserted mid-debounce (cycle 3 of 5): all outputs return to reset values at once, and no mode change follows release. With BLINK_CTRL_AUTO_EN and no presses, MODE advances every 40 cycles.
